prim_present_seq: RTL and testbench

Iterative, multi-cycle PRESENT engine that computes one cipher round per clock, with a valid/ready request and response handshake. It is the area-optimised alternative to the fully unrolled combinational PRESENT primitive, for use by scramblers and low-throughput blocks. The block handles both encryption and decryption. For decryption it first expands the key by running the forward key schedule NumRounds times. An optional key cache skips that expansion when the same key is reused.

---
 rtl/prim_present_seq_if.sv | 11 +
 rtl/prim_present_seq.sv | 148 ++++++++++++++
 tb/tb_prim_present_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/prim_present_seq_if.sv
// prim_present_seq_if: request/response handshake bundle of the iterative PRESENT engine.
interface prim_present_seq_if #(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128
);
  logic                 valid_i, ready_o, dec_i, valid_o, ready_i;
  logic [DataWidth-1:0] data_i, data_o;
  logic [KeyWidth-1:0]  key_i;
  modport slave  (input valid_i, dec_i, data_i, key_i, ready_i, output ready_o, valid_o, data_o);
  modport master (output valid_i, dec_i, data_i, key_i, ready_i, input ready_o, valid_o, data_o);
endinterface

// File: rtl/prim_present_seq.sv
// prim_present_seq: one-round-per-cycle PRESENT encrypt/decrypt engine with valid/ready handshake.
// Define PRIM_PRESENT_SEQ_KEYCACHE_EN to cache the last expanded key and skip decrypt key expansion.
module prim_present_seq #(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128,
  parameter int NumRounds = 31
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  output logic                busy_o,
  prim_present_seq_if.slave   bus
);
  localparam logic [63:0] Sbox    = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SboxInv = 64'hA970364BD21C8FE5;
  localparam int          RcLo    = (KeyWidth == 128) ? 62 : 15;

  function automatic logic [DataWidth-1:0] sub(logic [DataWidth-1:0] s, logic [63:0] t);
    for (int i = 0; i < DataWidth / 4; i++) s[4*i +: 4] = t[{s[4*i +: 4], 2'b00} +: 4];
    return s;
  endfunction

  function automatic logic [DataWidth-1:0] perm(logic [DataWidth-1:0] s, logic inv);
    logic [DataWidth-1:0] o;
    o = '0;
    for (int i = 0; i < DataWidth; i++) begin
      int p;
      p = (i == DataWidth - 1) ? i : (i * DataWidth / 4) % (DataWidth - 1);
      if (inv) o[i] = s[p];
      else o[p] = s[i];
    end
    return o;
  endfunction

  function automatic logic [KeyWidth-1:0] upd_key(logic [KeyWidth-1:0] k, logic [4:0] r);
    logic [KeyWidth-1:0] o;
    o = {k[KeyWidth-62:0], k[KeyWidth-1:KeyWidth-61]};
    o[KeyWidth-1 -: 4] = Sbox[{o[KeyWidth-1 -: 4], 2'b00} +: 4];
    if (KeyWidth == 128) o[KeyWidth-5 -: 4] = Sbox[{o[KeyWidth-5 -: 4], 2'b00} +: 4];
    o[RcLo +: 5] = o[RcLo +: 5] ^ r;
    return o;
  endfunction

  // Undoes the forward update that used round index NumRounds+1-r.
  function automatic logic [KeyWidth-1:0] inv_key(logic [KeyWidth-1:0] k, logic [4:0] r);
    logic [KeyWidth-1:0] o;
    o = k;
    o[RcLo +: 5] = o[RcLo +: 5] ^ (5'(NumRounds) + 5'd1 - r);
    o[KeyWidth-1 -: 4] = SboxInv[{o[KeyWidth-1 -: 4], 2'b00} +: 4];
    if (KeyWidth == 128) o[KeyWidth-5 -: 4] = SboxInv[{o[KeyWidth-5 -: 4], 2'b00} +: 4];
    return {o[60:0], o[KeyWidth-1:61]};
  endfunction

  typedef enum logic [1:0] {Idle, KeyExp, Crypt, Done} state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d, out_q, out_d, mix, st_nxt;
  logic [KeyWidth-1:0]  key_q, key_d, kf, k_nxt, hit_key;
  logic [4:0]           rnd_q, rnd_d;
  logic                 dec_q, dec_d, last, acc, hit;

  assign mix    = data_q ^ key_q[KeyWidth-1 -: DataWidth];
  assign kf     = upd_key(key_q, rnd_q);
  assign st_nxt = dec_q ? sub(perm(mix, 1'b1), SboxInv) : perm(sub(mix, Sbox), 1'b0);
  assign k_nxt  = dec_q ? inv_key(key_q, rnd_q) : kf;
  assign last   = rnd_q == 5'(NumRounds);

  assign bus.ready_o = state_q == Idle && !rst_i && !clear_i;
  assign bus.valid_o = state_q == Done;
  assign bus.data_o  = out_q;
  assign busy_o      = state_q == KeyExp || state_q == Crypt;
  assign acc         = bus.valid_i && bus.ready_o;

`ifdef PRIM_PRESENT_SEQ_KEYCACHE_EN
  logic [KeyWidth-1:0] ckey_q, ckey_d, cexp_q, cexp_d;
  logic                cvld_q, cvld_d;

  assign hit     = cvld_q && bus.dec_i && bus.key_i == ckey_q;
  assign hit_key = cexp_q;

  // The final forward key of an encryption is exactly the decrypt starting key.
  always_comb begin
    ckey_d = ckey_q;
    cexp_d = cexp_q;
    cvld_d = cvld_q;
    if (clear_i) cvld_d = 1'b0;
    else if (acc && !hit) begin
      ckey_d = bus.key_i;
      cvld_d = 1'b0;
    end else if (last && (state_q == KeyExp || (state_q == Crypt && !dec_q))) begin
      cexp_d = kf;
      cvld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cvld_q <= rst_i ? 1'b0 : cvld_d;
    ckey_q <= ckey_d;
    cexp_q <= cexp_d;
  end
`else
  assign hit     = 1'b0;
  assign hit_key = bus.key_i;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    out_d   = out_q;
    if (clear_i) state_d = Idle;
    else if (acc) begin
      data_d  = bus.data_i;
      key_d   = hit ? hit_key : bus.key_i;
      rnd_d   = 5'd1;
      dec_d   = bus.dec_i;
      state_d = (bus.dec_i && !hit) ? KeyExp : Crypt;
    end else if (state_q == KeyExp) begin
      key_d   = kf;
      rnd_d   = last ? 5'd1 : rnd_q + 5'd1;
      state_d = last ? Crypt : KeyExp;
    end else if (state_q == Crypt) begin
      data_d = st_nxt;
      key_d  = k_nxt;
      rnd_d  = rnd_q + 5'd1;
      if (last) begin
        out_d   = st_nxt ^ k_nxt[KeyWidth-1 -: DataWidth];
        state_d = Done;
      end
    end else if (state_q == Done && bus.ready_i) state_d = Idle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
    data_q <= data_d;
    key_q  <= key_d;
    rnd_q  <= rnd_d;
    dec_q  <= dec_d;
  end
endmodule

// File: tb/tb_prim_present_seq.sv
// tb_prim_present_seq: randomized PRESENT-80 checks against a round-key-array reference model.
module tb_prim_present_seq;
  localparam int DW = 64, KW = 80, NR = 31;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, busy;
  always #5 clk = ~clk;

  prim_present_seq_if #(.DataWidth(DW), .KeyWidth(KW)) bus ();

  prim_present_seq #(.DataWidth(DW), .KeyWidth(KW), .NumRounds(NR)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy), .bus(bus.slave)
  );

  int n_cmp = 0, n_bad = 0;
  int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  logic [63:0] rk [1:32];
  logic [79:0] c_key = '0, key_cur;
  bit          c_ok = 0;
  logic [63:0] exp_q;
  int          lat_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sub(input logic [63:0] s, input bit inv);
    for (int j = 0; j < 16; j++) begin
      int x;
      x = int'(s[4*j +: 4]);
      if (inv) begin
        for (int v = 0; v < 16; v++) if (sb[v] == x) s[4*j +: 4] = 4'(v);
      end else s[4*j +: 4] = 4'(sb[x]);
    end
    return s;
  endfunction

  // Bit j travels to 16*(j mod 4) + j/4.
  function automatic logic [63:0] pl(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    for (int j = 0; j < 64; j++) begin
      int p;
      p = 16 * (j % 4) + j / 4;
      if (inv) t[j] = s[p];
      else t[p] = s[j];
    end
    return t;
  endfunction

  task automatic gen_keys(input logic [79:0] k);
    logic [159:0] kk;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      kk = {k, k};
      k = kk[98:19];
      k[79:76] = 4'(sb[k[79:76]]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
  endtask

  task automatic model(input bit dec, input logic [63:0] d, input logic [79:0] k, output logic [63:0] r);
    gen_keys(k);
    r = d;
    if (!dec) begin
      for (int i = 1; i <= 31; i++) r = pl(sub(r ^ rk[i], 0), 0);
      r = r ^ rk[32];
    end else begin
      r = r ^ rk[32];
      for (int i = 31; i >= 1; i--) r = sub(pl(r, 1), 1) ^ rk[i];
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input bit dec, input logic [63:0] d, input logic [79:0] k);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    model(dec, d, k, exp_q);
`ifdef PRIM_PRESENT_SEQ_KEYCACHE_EN
    hit = dec && c_ok && k == c_key;
`endif
    lat_q = (dec && !hit) ? 2 * NR + 1 : NR + 1;
    key_cur = k;
    bus.valid_i = 1'b1;
    bus.dec_i   = dec;
    bus.data_i  = d;
    bus.key_i   = k;
    #1;
    while (!bus.ready_o && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.data_i  = {$urandom, $urandom};
    #1;
    check("busy_run", 64'(busy), 64'd1);
  endtask

  task automatic finish_x(input int bp);
    int          c;
    logic [63:0] held;
    c = 1;
    while (!bus.valid_o && c < 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("latency", 64'(c), 64'(lat_q));
    check("data", bus.data_o, exp_q);
    check("busy_done", 64'(busy), 64'd0);
    held = bus.data_o;
    for (int i = 0; i < bp; i++) begin
      bus.valid_i = 1'b1;
      @(negedge clk);
      #1;
      check("bp_valid", 64'(bus.valid_o), 64'd1);
      check("bp_data", bus.data_o, held);
      check("bp_ready", 64'(bus.ready_o), 64'd0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    #1;
    check("ready_after", 64'(bus.ready_o), 64'd1);
    check("valid_after", 64'(bus.valid_o), 64'd0);
    c_key = key_cur;
    c_ok  = 1;
  endtask

  task automatic xact(input bit dec, input logic [63:0] d, input logic [79:0] k, input int bp);
    issue(dec, d, k);
    finish_x(bp);
  endtask

  initial begin
    logic [79:0] kpool [3];
    logic [79:0] k;
    logic [63:0] d;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.dec_i   = 1'b0;
    bus.data_i  = '0;
    bus.key_i   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", bus.data_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);

    issue(0, 64'd0, 80'd0);
    exp_q = 64'h5579C1387B228445;
    finish_x(0);
    issue(0, '1, '1);
    exp_q = 64'h3333DCD3213210D2;
    finish_x(10);
    issue(1, 64'h3333DCD3213210D2, '1);
    exp_q = 64'hFFFFFFFFFFFFFFFF;
    finish_x(2);

    // Abort a decrypt mid-flight; the cached key must be forgotten.
    k = {16'($urandom), $urandom, $urandom};
    d = {$urandom, $urandom};
    xact(0, d, k, 0);
    issue(1, d, k);
    repeat (14) @(negedge clk);
    clear = 1'b1;
    #1;
    check("clear_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    c_ok  = 0;
    #1;
    check("clear_valid", 64'(bus.valid_o), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_idle", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    issue(1, d, k);
    check("clear_refill_lat", 64'(lat_q), 64'(2 * NR + 1));
    finish_x(0);

    // Reset during CRYPT.
    issue(0, {$urandom, $urandom}, k);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    c_ok = 0;
    #1;
    check("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", bus.data_o, 64'd0);
    check("mid_rst_ready_after", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    issue(0, '1, 80'd0);
    exp_q = 64'hA112FFC72F68417B;
    finish_x(0);

    for (int i = 0; i < 3; i++) kpool[i] = {16'($urandom), $urandom, $urandom};
    for (int i = 0; i < 16; i++)
      xact(1'($urandom_range(0, 1)), {$urandom, $urandom}, kpool[$urandom_range(0, 2)],
           int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
